// File: rtl/scarf_regmap_gen.sv
// Parametrised SCARF slave register map: RW control bank below RO_BASE, RO status bank above.
// Optional SCARF_REGMAP_STICKY_STATUS_EN makes each status byte sticky with clear-on-read.
module scarf_regmap_gen #(
    parameter logic [6:0] SLAVE_ID = 7'h01,
    parameter int         NUM_REGS = 8,
    parameter int         RO_BASE  = 6,
    parameter bit         WRAP     = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst_n_sync,
    input  logic [7:0]                        data_in,
    input  logic                              data_in_valid,
    input  logic                              data_in_finished,
    input  logic [6:0]                        slave_id,
    input  logic                              rnw,
    input  logic [8*(NUM_REGS-RO_BASE)-1:0]   status_in,
    output logic [7:0]                        read_data_out,
    output logic [8*RO_BASE-1:0]              regs_out,
    output logic [NUM_REGS-1:0]               wr_strobe,
    output logic                              addr_err
);

    localparam int AW  = $clog2(NUM_REGS);
    localparam int NRO = NUM_REGS - RO_BASE;
    localparam logic [AW-1:0] ADDR_ONE = 1;

    logic                    r_first;
    logic                    r_done;
    logic                    r_bad;
    logic                    r_addr_err;
    logic [AW-1:0]           r_addr;
    logic [8*RO_BASE-1:0]    r_regs;
    logic [NUM_REGS-1:0]     r_wr_strobe;

    logic                    w_valid_slave;
    logic                    w_byte;
    logic                    w_active;
    logic                    w_in_rw;
    logic                    w_write;
    logic                    w_last;
    logic                    w_start_bad;
    int                      w_addr_idx;
    logic [8*NRO-1:0]        w_status;

    assign w_valid_slave = (slave_id == SLAVE_ID);
    // A finishing pulse wins over a coincident byte, so that byte is dropped here.
    assign w_byte        = w_valid_slave && data_in_valid && !data_in_finished;
    assign w_active      = !r_first && !r_done && !r_bad;
    assign w_addr_idx    = int'(r_addr);
    assign w_in_rw       = (w_addr_idx < RO_BASE);
    assign w_write       = w_byte && !rnw && w_active && w_in_rw;
    assign w_last        = (w_addr_idx == NUM_REGS - 1);
    assign w_start_bad   = (int'(data_in) >= NUM_REGS);

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            r_first    <= 1'b1;
            r_done     <= 1'b0;
            r_bad      <= 1'b0;
            r_addr_err <= 1'b0;
            r_addr     <= '0;
        end else if (data_in_finished) begin
            r_first <= 1'b1;
            r_done  <= 1'b0;
            r_bad   <= 1'b0;
            r_addr  <= '0;
        end else if (w_byte) begin
            if (r_first) begin
                r_first    <= 1'b0;
                r_addr     <= data_in[AW-1:0];
                r_bad      <= w_start_bad;
                r_addr_err <= w_start_bad;
            end else if (!r_done && !r_bad) begin
                if (w_last) begin
                    if (WRAP) r_addr <= '0;
                    else      r_done <= 1'b1;
                end else begin
                    r_addr <= r_addr + ADDR_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            r_regs      <= '0;
            r_wr_strobe <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_wr_strobe[k] <= w_write && (w_addr_idx == k);
            end
            for (int k = 0; k < RO_BASE; k++) begin
                if (w_write && (w_addr_idx == k)) r_regs[8*k +: 8] <= data_in;
            end
        end
    end

`ifdef SCARF_REGMAP_STICKY_STATUS_EN
    logic             w_rd_consume;
    logic [8*NRO-1:0] r_sticky;

    assign w_rd_consume = w_byte && rnw && w_active && !w_in_rw;

    // Reloading with this cycle's status on a consumed read lets a fresh set beat the clear.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            r_sticky <= '0;
        end else begin
            for (int k = 0; k < NRO; k++) begin
                if (w_rd_consume && (w_addr_idx == RO_BASE + k))
                    r_sticky[8*k +: 8] <= status_in[8*k +: 8];
                else
                    r_sticky[8*k +: 8] <= r_sticky[8*k +: 8] | status_in[8*k +: 8];
            end
        end
    end

    assign w_status = r_sticky;
`else
    assign w_status = status_in;
`endif

    always_comb begin
        read_data_out = 8'h00;
        if (w_valid_slave && rnw) begin
            if (r_first) begin
                read_data_out = {1'b0, SLAVE_ID};
            end else if (!r_done && !r_bad) begin
                if (w_in_rw)
                    read_data_out = r_regs[8*w_addr_idx +: 8];
                else if (w_addr_idx < NUM_REGS)
                    read_data_out = w_status[8*(w_addr_idx-RO_BASE) +: 8];
            end
        end
    end

    assign regs_out  = r_regs;
    assign wr_strobe = r_wr_strobe;
    assign addr_err  = r_addr_err;

endmodule
